// File: rtl/sdft_sched_pkg.sv
// Shared sizing for the sdft scheduler slice.
package sdft_sched_pkg;

  localparam int DATA_WIDTH      = 8;
  localparam int FREQ_BINS       = 8;
  localparam int FREQ_W          = 12;
  localparam int BIN_ADDR_W      = 3;
  localparam int DEF_SWEEP_EVERY = 64;
  localparam int DEF_TIMEOUT     = 255;

  function automatic logic is_last_bin(input logic [BIN_ADDR_W-1:0] bin);
    return bin == BIN_ADDR_W'(FREQ_BINS - 1);
  endfunction

endpackage

// File: rtl/sdft_sched_sample_hold.sv
// One-entry sample holding register; a sample arriving while it is full is dropped.
module sample_hold
  import sdft_sched_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] in_sample,
  input  logic                         in_valid,
  input  logic                         consume,
  output logic signed [DATA_WIDTH-1:0] hold_data,
  output logic                         hold_full,
  output logic                         overrun
);

  // A load in the same cycle as a consume refills the entry instead of overrunning.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data <= '0;
      hold_full <= 1'b0;
      overrun   <= 1'b0;
    end else if (in_valid && hold_full && !consume) begin
      overrun <= 1'b1;
    end else if (in_valid) begin
      hold_data <= in_sample;
      hold_full <= 1'b1;
    end else if (consume) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: rtl/sdft_sched.sv
// Scheduler in front of the sdft core: one start per sample, periodic bin sweeps to a valid/ready stream.
module sdft_sched
  import sdft_sched_pkg::*;
#(
  parameter int SWEEP_EVERY = DEF_SWEEP_EVERY,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] in_sample,
  input  logic                         in_valid,
  input  logic                         sweep_req,
  output logic signed [DATA_WIDTH-1:0] sdft_sample,
  output logic                         sdft_start,
  output logic                         sdft_read,
  output logic [BIN_ADDR_W-1:0]        sdft_bin_addr,
  input  logic                         sdft_ready,
  input  logic [FREQ_W-1:0]            sdft_real,
  input  logic [FREQ_W-1:0]            sdft_imag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BIN_ADDR_W-1:0]        out_bin,
  output logic [FREQ_W-1:0]            out_real,
  output logic [FREQ_W-1:0]            out_imag,
  output logic                         out_last,
  output logic                         overrun,
  output logic                         timeout_err
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {IDLE, S_REQ, S_WAIT, R_REQ, R_WAIT, EMIT} state_t;

  state_t                       state;
  logic [WAIT_W-1:0]            wait_cnt;
  logic [CNT_W-1:0]             sample_cnt;
  logic [BIN_ADDR_W-1:0]        bin_cnt;
  logic                         sweep_active;
  logic                         consume;
  logic                         wait_expired;
  logic                         in_wait;
  logic signed [DATA_WIDTH-1:0] hold_data;
  logic                         hold_full;

  assign consume      = (state == IDLE) && hold_full && sdft_ready;
  assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));
  assign in_wait      = (state == S_REQ) || (state == S_WAIT) ||
                        (state == R_REQ) || (state == R_WAIT);

  sample_hold u_hold (
    .clk       (clk),
    .reset     (reset),
    .in_sample (in_sample),
    .in_valid  (in_valid),
    .consume   (consume),
    .hold_data (hold_data),
    .hold_full (hold_full),
    .overrun   (overrun)
  );

  // Samples always win over bin reads in IDLE so the sliding DFT never skips an update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      sample_cnt    <= '0;
      bin_cnt       <= '0;
      sweep_active  <= 1'b0;
      sdft_sample   <= '0;
      sdft_start    <= 1'b0;
      sdft_read     <= 1'b0;
      sdft_bin_addr <= '0;
      out_valid     <= 1'b0;
      out_bin       <= '0;
      out_real      <= '0;
      out_imag      <= '0;
      out_last      <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      if (sweep_req && !sweep_active)
        sweep_active <= 1'b1;
      if (in_wait && wait_expired) begin
        timeout_err  <= 1'b1;
        sdft_start   <= 1'b0;
        sdft_read    <= 1'b0;
        sweep_active <= 1'b0;
        bin_cnt      <= '0;
        wait_cnt     <= '0;
        state        <= IDLE;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
        case (state)
          IDLE: begin
            wait_cnt <= '0;
            if (hold_full && sdft_ready) begin
              sdft_sample <= hold_data;
              sdft_start  <= 1'b1;
              state       <= S_REQ;
            end else if (sweep_active && sdft_ready) begin
              sdft_read     <= 1'b1;
              sdft_bin_addr <= bin_cnt;
              state         <= R_REQ;
            end
          end
          S_REQ: if (!sdft_ready) begin
            sdft_start <= 1'b0;
            wait_cnt   <= '0;
            state      <= S_WAIT;
          end
          // A counter trigger during an active sweep is simply absorbed, never queued.
          S_WAIT: if (sdft_ready) begin
            state <= IDLE;
            if (SWEEP_EVERY != 0 && sample_cnt == CNT_W'(SWEEP_EVERY - 1)) begin
              sample_cnt   <= '0;
              sweep_active <= 1'b1;
            end else begin
              sample_cnt <= sample_cnt + 1'b1;
            end
          end
          R_REQ: if (!sdft_ready) begin
            sdft_read <= 1'b0;
            wait_cnt  <= '0;
            state     <= R_WAIT;
          end
          R_WAIT: if (sdft_ready) begin
            out_real  <= sdft_real;
            out_imag  <= sdft_imag;
            out_bin   <= bin_cnt;
            out_last  <= is_last_bin(bin_cnt);
            out_valid <= 1'b1;
            state     <= EMIT;
          end
          EMIT: begin
            wait_cnt <= '0;
            if (out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (out_last) begin
                sweep_active <= 1'b0;
                bin_cnt      <= '0;
              end else begin
                bin_cnt <= bin_cnt + 1'b1;
              end
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
